// File: rtl/copier_memory_responder_pkg.sv
// Shared encodings and widths for the copier memory responder and the masters that lock to its phase.
package copier_memory_responder_pkg;

    localparam int ADDRESS_BITS = 8;
    localparam int DATA_BITS    = 16;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic {
        PHASE_READ  = 1'b0,
        PHASE_WRITE = 1'b1
    } memPhase_t;

    function automatic logic isWrite(input logic readWriteMode);
        return readWriteMode == RAM_WRITE;
    endfunction

endpackage

// File: rtl/memory_cycle_phase.sv
// Two-slot memory cycle sequencer: read slot then write slot; a disabled cycle
// always finishes its write slot and then parks in the read slot.
module memory_cycle_phase
    import copier_memory_responder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic phase
);

    memPhase_t phaseReg;
    memPhase_t phaseNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phaseReg <= PHASE_READ;
        end else begin
            phaseReg <= phaseNext;
        end
    end

    always_comb begin
        phaseNext = phaseReg;
        case (phaseReg)
            PHASE_READ:  phaseNext = enable ? PHASE_WRITE : PHASE_READ;
            PHASE_WRITE: phaseNext = PHASE_READ;
            default:     phaseNext = PHASE_READ;
        endcase
    end

    always_comb begin
        phase = (phaseReg == PHASE_WRITE);
    end

endmodule

// File: rtl/copier_memory_responder.sv
// Serves a read port and a write port from one single-port synchronous RAM by
// alternating read and write slots; also counts writes and flags read-port misuse.
module copier_memory_responder
    import copier_memory_responder_pkg::*;
#(
    parameter int addrBits  = ADDRESS_BITS,
    parameter int dataBits  = DATA_BITS,
    parameter int countBits = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 phase,
    input  logic [addrBits-1:0]  readAddress,
    input  logic                 readReadWriteMode,
    output logic [dataBits-1:0]  readDataOut,
    input  logic [addrBits-1:0]  writeAddress,
    input  logic                 writeReadWriteMode,
    input  logic [dataBits-1:0]  writeDataIn,
    output logic [addrBits-1:0]  ramAddress,
    output logic                 ramWriteEnable,
    output logic [dataBits-1:0]  ramDataIn,
    input  logic [dataBits-1:0]  ramDataOut,
    output logic [countBits-1:0] writeCount,
    output logic                 protocolError
);

    localparam logic [countBits-1:0] COUNT_ONE = countBits'(1);

    logic                 commitWrite;
    logic [dataBits-1:0]  readDataReg;
    logic [countBits-1:0] writeCountReg;
    logic                 protocolErrorReg;

    memory_cycle_phase u_phase (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .phase  (phase)
    );

    // Write slot commits only when the write port asks; reset gates the strobe
    // immediately so a write caught mid-cycle never reaches the RAM.
    always_comb begin
        commitWrite    = phase & isWrite(writeReadWriteMode);
        ramWriteEnable = commitWrite & ~reset;
        ramAddress     = phase ? writeAddress : readAddress;
        ramDataIn      = writeDataIn;
    end

    // ramDataOut at the end of the write slot holds the word addressed in the read slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readDataReg <= '0;
        end else if (phase) begin
            readDataReg <= ramDataOut;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeCountReg <= '0;
        end else if (commitWrite && !(&writeCountReg)) begin
            writeCountReg <= writeCountReg + COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocolErrorReg <= 1'b0;
        end else if (!phase && enable && isWrite(readReadWriteMode)) begin
            protocolErrorReg <= 1'b1;
        end
    end

    assign readDataOut   = readDataReg;
    assign writeCount    = writeCountReg;
    assign protocolError = protocolErrorReg;

endmodule

// File: tb/tb_copier_memory_responder.sv
// Directed bench: behavioural sync RAM, shadow memory model and a read-data scoreboard queue.
module tb_copier_memory_responder;
    import copier_memory_responder_pkg::*;

    localparam int AB = ADDRESS_BITS;
    localparam int DB = DATA_BITS;
    localparam int CB = 4;
    localparam int COUNT_MAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          phase;
    logic [AB-1:0] readAddress;
    logic          readReadWriteMode;
    logic [DB-1:0] readDataOut;
    logic [AB-1:0] writeAddress;
    logic          writeReadWriteMode;
    logic [DB-1:0] writeDataIn;
    logic [AB-1:0] ramAddress;
    logic          ramWriteEnable;
    logic [DB-1:0] ramDataIn;
    logic [DB-1:0] ramDataOut;
    logic [CB-1:0] writeCount;
    logic          protocolError;

    logic [DB-1:0] ram [0:(1<<AB)-1];
    logic          bdWe = 1'b0;
    logic [AB-1:0] bdAddr = '0;
    logic [DB-1:0] bdData = '0;

    logic [DB-1:0] model [0:(1<<AB)-1];
    logic [DB-1:0] expQ [$];
    logic [DB-1:0] lastRead;
    logic [DB-1:0] expRead;
    int            expCount;
    logic          expErr;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    // Single-port synchronous RAM with a backdoor used only for preloading.
    always @(posedge clk) begin
        if (bdWe) ram[bdAddr] <= bdData;
        else if (ramWriteEnable) ram[ramAddress] <= ramDataIn;
        ramDataOut <= ram[ramAddress];
    end

    copier_memory_responder #(.addrBits(AB), .dataBits(DB), .countBits(CB)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .phase              (phase),
        .readAddress        (readAddress),
        .readReadWriteMode  (readReadWriteMode),
        .readDataOut        (readDataOut),
        .writeAddress       (writeAddress),
        .writeReadWriteMode (writeReadWriteMode),
        .writeDataIn        (writeDataIn),
        .ramAddress         (ramAddress),
        .ramWriteEnable     (ramWriteEnable),
        .ramDataIn          (ramDataIn),
        .ramDataOut         (ramDataOut),
        .writeCount         (writeCount),
        .protocolError      (protocolError)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic bdWrite(input logic [AB-1:0] a, input logic [DB-1:0] d);
        bdWe = 1'b1; bdAddr = a; bdData = d;
        model[a] = d;
        @(negedge clk);
        bdWe = 1'b0;
    endtask

    // One full memory cycle, entered and left at a negedge inside the read slot.
    task automatic memCycle(input logic [AB-1:0] rAddr, input logic rMode,
                            input logic wMode, input logic [AB-1:0] wAddr, input logic [DB-1:0] wData);
        logic [DB-1:0] got;
        check("cycle_start_phase", phase, 0);
        readAddress = rAddr; readReadWriteMode = rMode;
        writeAddress = wAddr; writeReadWriteMode = wMode; writeDataIn = wData;
        #1;
        check("rd_slot_we", ramWriteEnable, 0);
        check("rd_slot_addr", ramAddress, rAddr);
        expQ.push_back(model[rAddr]);
        if (wMode == RAM_WRITE) begin
            model[wAddr] = wData;
            if (expCount != COUNT_MAX) expCount++;
        end
        if (rMode == RAM_WRITE) expErr = 1'b1;
        @(negedge clk);
        check("wr_slot_phase", phase, 1);
        check("wr_slot_we", ramWriteEnable, wMode);
        check("wr_slot_addr", ramAddress, wAddr);
        check("wr_slot_data", ramDataIn, wData);
        check("rd_not_early", readDataOut, lastRead);
        @(negedge clk);
        got = expQ.pop_front();
        check("read_data", readDataOut, got);
        lastRead = got;
        check("write_count", writeCount, expCount);
        check("protocol_error", protocolError, expErr);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        readAddress = '0; readReadWriteMode = RAM_READ;
        writeAddress = 8'h55; writeReadWriteMode = RAM_WRITE; writeDataIn = 16'hFFFF;
        expCount = 0; expErr = 1'b0; lastRead = '0;
        @(negedge clk);
        bdWrite(8'h10, 16'hBEEF);
        bdWrite(8'h20, 16'h5555);
        bdWrite(8'h30, 16'h3333);

        // Reset state, with a write requested on the port
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_phase", phase, 0);
            check("rst_we", ramWriteEnable, 0);
            check("rst_rdata", readDataOut, 0);
            check("rst_count", writeCount, 0);
            check("rst_err", protocolError, 0);
        end
        writeReadWriteMode = RAM_READ; readAddress = 8'h30;
        reset = 1'b0;

        // Phase sequence after release
        check("rel_phase", phase, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("seq_phase", phase, (i % 2 == 0) ? 1 : 0);
            check("seq_we", ramWriteEnable, 0);
        end
        lastRead = 16'h3333;
        check("seq_rdata", readDataOut, lastRead);

        // Read latency on a preloaded word
        memCycle(8'h10, RAM_READ, RAM_READ, 8'h00, 16'h0000);
        // Same-address hazard: old word first, new word next cycle
        memCycle(8'h20, RAM_READ, RAM_WRITE, 8'h20, 16'h1234);
        memCycle(8'h20, RAM_READ, RAM_READ, 8'h00, 16'h0000);

        // Back-to-back writes past counter saturation
        for (int i = 0; i < 20; i++) begin
            memCycle(8'h10, RAM_READ, RAM_WRITE, AB'(8'h40 + i), DB'(16'hA000 + i));
        end
        for (int i = 0; i < 20; i++) begin
            expRead = DB'(16'hA000 + i);
            check("sat_ram", ram[8'h40 + i], expRead);
        end

        // Read port requesting a write
        memCycle(8'h10, RAM_WRITE, RAM_READ, 8'h10, 16'hDEAD);
        check("perr_ram", ram[8'h10], 16'hBEEF);
        memCycle(8'h20, RAM_READ, RAM_READ, 8'h00, 16'h0000);

        // Reset during the write slot with a write pending
        readAddress = 8'h10; readReadWriteMode = RAM_READ;
        writeAddress = 8'h30; writeReadWriteMode = RAM_WRITE; writeDataIn = 16'h0077;
        @(negedge clk);
        check("pend_we", ramWriteEnable, 1);
        reset = 1'b1;
        #1;
        check("arst_we", ramWriteEnable, 0);
        check("arst_phase", phase, 0);
        check("arst_count", writeCount, 0);
        check("arst_err", protocolError, 0);
        check("arst_rdata", readDataOut, 0);
        @(negedge clk);
        check("arst_ram", ram[8'h30], 16'h3333);
        writeReadWriteMode = RAM_READ;
        reset = 1'b0;
        expCount = 0; expErr = 1'b0; lastRead = '0;

        // Enable dropped in the write slot
        memCycle(8'h10, RAM_READ, RAM_READ, 8'h00, 16'h0000);
        readAddress = 8'h20;
        expQ.push_back(model[8'h20]);
        @(negedge clk);
        check("drop_phase1", phase, 1);
        enable = 1'b0;
        @(negedge clk);
        check("drop_phase0", phase, 0);
        expRead = expQ.pop_front();
        check("drop_rdata", readDataOut, expRead);
        lastRead = expRead;
        readAddress = 8'h10; readReadWriteMode = RAM_WRITE;
        writeAddress = 8'h30; writeReadWriteMode = RAM_WRITE; writeDataIn = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_phase", phase, 0);
            check("frz_we", ramWriteEnable, 0);
            check("frz_rdata", readDataOut, lastRead);
            check("frz_count", writeCount, 0);
            check("frz_err", protocolError, 0);
        end
        readReadWriteMode = RAM_READ; writeReadWriteMode = RAM_READ;
        enable = 1'b1;
        memCycle(8'h10, RAM_READ, RAM_READ, 8'h00, 16'h0000);
        check("frz_ram", ram[8'h30], 16'h3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
